// File: rtl/color_track_pkg.sv
// Shared definitions for the region colour tracker: default frame geometry
// and the result-latching FSM state encoding.
package color_track_pkg;

   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SCAN  = 2'd2
   } track_state_e;

endpackage

// File: rtl/region_color_tracker_region_index.sv
// Maps a pixel column onto its vertical strip with a comparator chain
// against the strip boundaries k*RW, so no divider is needed. Columns at or
// beyond NUM_REGIONS*RW (the remainder) are flagged as out of range.
module region_index #(
   parameter int NUM_REGIONS = 4,
   parameter int RW          = 160,
   parameter int X_W         = 10,
   parameter int IDX_W       = 2
) (
   input  logic [X_W-1:0]   x,
   output logic             in_range,
   output logic [IDX_W-1:0] idx
);

   logic [31:0] x_ext;
   assign x_ext = 32'(x);

   // Highest boundary the column has reached selects the strip.
   always_comb begin
      in_range = (x_ext < 32'(NUM_REGIONS * RW));
      idx      = '0;
      for (int k = 1; k < NUM_REGIONS; k++) begin
         if (x_ext >= 32'(k * RW)) idx = IDX_W'(k);
      end
   end

endmodule

// File: rtl/region_color_tracker.sv
// Per-frame, per-strip colour hit counter. Counts classifier hits per
// vertical strip during a frame, snapshots the counts at the frame's end
// pixel, applies on/off hysteresis per strip and scans for the dominant strip.
module region_color_tracker
   import color_track_pkg::*;
#(
   parameter int H_RES       = DEF_H_RES,
   parameter int V_RES       = DEF_V_RES,
   parameter int NUM_REGIONS = 4,
   parameter int CNT_W       = 17,
   parameter int X_W         = 10,
   parameter int Y_W         = 10,
   parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   pix_valid,
   input  logic [X_W-1:0]         x,
   input  logic [Y_W-1:0]         y,
   input  logic                   hit,
   input  logic [CNT_W-1:0]       thr_on,
   input  logic [CNT_W-1:0]       thr_off,
   output logic [NUM_REGIONS-1:0] detected,
   output logic [IDX_W-1:0]       best_region,
   output logic                   best_valid,
   output logic                   frame_done,
   output logic                   frame_abort,
   input  logic [IDX_W-1:0]       rd_sel,
   output logic [CNT_W-1:0]       rd_count
);

   localparam int               RW       = H_RES / NUM_REGIONS;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGIONS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Stage 0: live counters; stage 1: frame snapshot; stage 2: argmax scan.
   logic [CNT_W-1:0] cnt_p0    [NUM_REGIONS];
   logic [CNT_W-1:0] shadow_p1 [NUM_REGIONS];
   logic [CNT_W-1:0] run_max_p2;
   logic [IDX_W-1:0] run_arg_p2;
   logic [IDX_W-1:0] scan_idx;
   logic             in_frame;

   track_state_e     state_q, state_d;
   logic             do_latch, do_scan, scan_last;

   logic             px_in_range;
   logic [IDX_W-1:0] px_idx;
   logic             start_px, end_px, y_ok, cnt_hit;

   logic [CNT_W-1:0] scan_val;
   logic             scan_take;
   logic [CNT_W-1:0] next_max;
   logic [IDX_W-1:0] next_arg;

   region_index #(
      .NUM_REGIONS (NUM_REGIONS),
      .RW          (RW),
      .X_W         (X_W),
      .IDX_W       (IDX_W)
   ) u_region_index (
      .x        (x),
      .in_range (px_in_range),
      .idx      (px_idx)
   );

   assign start_px = pix_valid && (x == '0) && (y == '0);
   assign end_px   = pix_valid && in_frame && (x == X_LAST) && (y == Y_LAST);
   assign y_ok     = (32'(y) < 32'(V_RES));
   // The start pixel counts toward the frame it opens.
   assign cnt_hit  = pix_valid && hit && px_in_range && y_ok && (in_frame || start_px);

   // Frame tracking and saturating per-strip counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame    <= 1'b0;
         frame_abort <= 1'b0;
         for (int i = 0; i < NUM_REGIONS; i++) cnt_p0[i] <= '0;
      end else if (!en) begin
         in_frame    <= 1'b0;
         frame_abort <= 1'b0;
         for (int i = 0; i < NUM_REGIONS; i++) cnt_p0[i] <= '0;
      end else begin
         frame_abort <= start_px && in_frame;
         if (start_px)    in_frame <= 1'b1;
         else if (end_px) in_frame <= 1'b0;
         for (int i = 0; i < NUM_REGIONS; i++) begin
            if (start_px)
               cnt_p0[i] <= (cnt_hit && (px_idx == IDX_W'(i))) ? CNT_W'(1) : '0;
            else if (cnt_hit && (px_idx == IDX_W'(i)))
               cnt_p0[i] <= sat_inc(cnt_p0[i]);
         end
      end
   end

   // Result FSM state register; runs independently of counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       state_q <= IDLE;
      else if (!en)  state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state and per-state strobes.
   always_comb begin
      state_d   = state_q;
      do_latch  = 1'b0;
      do_scan   = 1'b0;
      scan_last = 1'b0;
      case (state_q)
         IDLE:  if (end_px) state_d = LATCH;
         LATCH: begin
            do_latch = 1'b1;
            state_d  = SCAN;
         end
         SCAN: begin
            do_scan = 1'b1;
            if (scan_idx == LAST_IDX) begin
               scan_last = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Scan position walks the shadows once per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  scan_idx <= '0;
      else if (!en)             scan_idx <= '0;
      else if (do_scan)         scan_idx <= scan_last ? '0 : scan_idx + IDX_W'(1);
      else                      scan_idx <= '0;
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      scan_val  = shadow_p1[scan_idx];
      scan_take = (scan_idx == '0) || (scan_val > run_max_p2);
      next_max  = scan_take ? scan_val : run_max_p2;
      next_arg  = scan_take ? scan_idx : run_arg_p2;
   end

   // Snapshot, hysteresis flags and argmax results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGIONS; i++) shadow_p1[i] <= '0;
         detected    <= '0;
         run_max_p2  <= '0;
         run_arg_p2  <= '0;
         best_region <= '0;
         best_valid  <= 1'b0;
         frame_done  <= 1'b0;
      end else if (!en) begin
         for (int i = 0; i < NUM_REGIONS; i++) shadow_p1[i] <= '0;
         detected    <= '0;
         run_max_p2  <= '0;
         run_arg_p2  <= '0;
         best_region <= '0;
         best_valid  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (do_latch) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
               shadow_p1[i] <= cnt_p0[i];
               if (cnt_p0[i] > thr_on)       detected[i] <= 1'b1;
               else if (cnt_p0[i] < thr_off) detected[i] <= 1'b0;
            end
         end
         if (do_scan) begin
            run_max_p2 <= next_max;
            run_arg_p2 <= next_arg;
            if (scan_last) begin
               best_region <= next_arg;
               best_valid  <= |detected;
               frame_done  <= 1'b1;
            end
         end
      end
   end

   assign rd_count = (32'(rd_sel) < 32'(NUM_REGIONS)) ? shadow_p1[rd_sel] : '0;

endmodule

// File: tb/tb_region_color_tracker.sv
// Randomised bench for region_color_tracker on a shrunken frame geometry.
// A frame-level reference model predicts each frame's results; a monitor
// pops the prediction whenever frame_done pulses.
module tb_region_color_tracker;

   localparam int H  = 18;
   localparam int V  = 10;
   localparam int N  = 4;
   localparam int CW = 5;
   localparam int XW = 5;
   localparam int YW = 4;
   localparam int IW = 2;
   localparam int RW = H / N;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, en, pix_valid, hit;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CW-1:0] thr_on, thr_off;
   logic [N-1:0]  detected;
   logic [IW-1:0] best_region;
   logic [IW-1:0] rd_sel = '0;
   logic          best_valid, frame_done, frame_abort;
   logic [CW-1:0] rd_count;

   region_color_tracker #(
      .H_RES(H), .V_RES(V), .NUM_REGIONS(N), .CNT_W(CW),
      .X_W(XW), .Y_W(YW), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .x(x), .y(y),
      .hit(hit), .thr_on(thr_on), .thr_off(thr_off), .detected(detected),
      .best_region(best_region), .best_valid(best_valid),
      .frame_done(frame_done), .frame_abort(frame_abort),
      .rd_sel(rd_sel), .rd_count(rd_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   typedef struct packed {
      logic [N-1:0]          det;
      logic [IW-1:0]         best;
      logic                  bv;
      logic [N-1:0][CW-1:0]  cnt;
      logic [31:0]           end_cyc;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   bit           m_in_frame;
   int           m_cnt[N];
   logic [N-1:0] m_det;
   int           m_aborts = 0;
   int           aborts_seen = 0;
   int           tgt[N];

   task automatic model_reset();
      m_in_frame = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_det = '0;
      exp_q.delete();
   endtask

   task automatic model_pixel(int px, int py, bit h, int ton, int toff);
      bit   is_start;
      exp_t e;
      int   best, bc, s;
      is_start = (px == 0 && py == 0);
      if (is_start) begin
         if (m_in_frame) m_aborts++;
         m_in_frame = 1;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      if (m_in_frame && h && px < N * RW && py < V) m_cnt[px / RW]++;
      if (m_in_frame && !is_start && px == H - 1 && py == V - 1) begin
         best = 0;
         bc   = -1;
         for (int i = 0; i < N; i++) begin
            s = (m_cnt[i] > SAT) ? SAT : m_cnt[i];
            if (s > ton)       m_det[i] = 1'b1;
            else if (s < toff) m_det[i] = 1'b0;
            e.cnt[i] = CW'(s);
            if (s > bc) begin
               bc   = s;
               best = i;
            end
         end
         e.det     = m_det;
         e.best    = IW'(best);
         e.bv      = |m_det;
         e.end_cyc = cyc;
         exp_q.push_back(e);
         m_in_frame = 0;
      end
   endtask

   task automatic step(bit v, int px, int py, bit h);
      pix_valid = v;
      x         = XW'(px);
      y         = YW'(py);
      hit       = h;
      if (!en)    model_reset();
      else if (v) model_pixel(px, py, h, int'(thr_on), int'(thr_off));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   // Raster frame with random gaps and off-screen pixels; strip s gets its
   // first tgt[s] pixels marked as hits. rows < V leaves the frame open.
   task automatic run_frame(int ton, int toff, int rows);
      int ord[N];
      bit h;
      idle(2);
      thr_on  = CW'(ton);
      thr_off = CW'(toff);
      for (int i = 0; i < N; i++) ord[i] = 0;
      for (int py = 0; py < rows; py++) begin
         for (int px = 0; px < H; px++) begin
            while ($urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 1)
                  step(0, $urandom_range(0, 31), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
               else if ($urandom_range(0, 1) == 1)
                  step(1, $urandom_range(H, 31), $urandom_range(0, V - 1), 1);
               else
                  step(1, $urandom_range(0, H - 1), $urandom_range(V, 15), 1);
            end
            if (px < N * RW) begin
               h = (ord[px / RW] < tgt[px / RW]);
               ord[px / RW]++;
            end else begin
               h = 1'($urandom_range(0, 1));
            end
            step(1, px, py, h);
         end
      end
   endtask

   task automatic set_tgt(int a, int b, int c, int d);
      tgt[0] = a; tgt[1] = b; tgt[2] = c; tgt[3] = d;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         idle(1);
         n++;
      end
      chk("drain_pending_frames", exp_q.size(), 0);
   endtask

   // Monitor: every frame_done must match the oldest predicted frame.
   always @(negedge clk) begin
      exp_t e;
      if (frame_abort) aborts_seen++;
      if (frame_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - e.end_cyc, N + 2);
            chk("detected", detected, e.det);
            chk("best_region", best_region, e.best);
            chk("best_valid", best_valid, e.bv);
            for (int i = 0; i < N; i++) begin
               rd_sel = IW'(i);
               #1;
               chk("rd_count", rd_count, e.cnt[i]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1; pix_valid = 1'b0; x = '0; y = '0; hit = 1'b0;
      thr_on = '0; thr_off = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_detected", detected, 0);
      chk("rst_best_region", best_region, 0);
      chk("rst_best_valid", best_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_abort", frame_abort, 0);
      chk("rst_rd_count", rd_count, 0);
      rst = 1'b0;
      model_reset();
      idle(2);

      // Hits only in strip 0 over the whole frame; count saturates at 31.
      set_tgt(V * RW, 0, 0, 0);
      run_frame(20, 10, V);
      wait_idle();
      chk("strip0_detected", detected, 4'b0001);
      chk("strip0_best", best_region, 0);
      chk("strip0_valid", best_valid, 1);

      // Hysteresis on strip 2: 25 sets, 15 holds, 5 clears.
      set_tgt(0, 0, 25, 0);
      run_frame(20, 10, V);
      wait_idle();
      chk("hyst_set", detected, 4'b0100);
      set_tgt(0, 0, 15, 0);
      run_frame(20, 10, V);
      wait_idle();
      chk("hyst_hold", detected, 4'b0100);
      set_tgt(0, 0, 5, 0);
      run_frame(20, 10, V);
      wait_idle();
      chk("hyst_clear", detected, 4'b0000);
      chk("hyst_clear_valid", best_valid, 0);

      // Tie between strips 1 and 3 resolves to the lower index.
      set_tgt(0, 30, 0, 30);
      run_frame(20, 10, V);
      wait_idle();
      chk("tie_best", best_region, 1);
      chk("tie_detected", detected, 4'b1010);

      // End pixel outside a frame is ignored.
      step(1, H - 1, V - 1, 1);
      idle(10);

      // Restart mid-frame, then a complete frame with its own hits.
      set_tgt(V * RW, V * RW, V * RW, V * RW);
      run_frame(20, 10, 3);
      set_tgt(3, 7, 0, 12);
      run_frame(5, 2, V);
      wait_idle();

      // Randomised frames with random thresholds.
      for (int f = 0; f < 10; f++) begin
         set_tgt($urandom_range(0, V * RW), $urandom_range(0, V * RW),
                 $urandom_range(0, V * RW), $urandom_range(0, V * RW));
         run_frame($urandom_range(0, SAT), $urandom_range(0, SAT), V);
      end
      wait_idle();

      // en low for one cycle mid-frame clears everything.
      set_tgt(V * RW, V * RW, V * RW, V * RW);
      run_frame(5, 2, V);
      wait_idle();
      chk("pre_en_detected", detected, 4'b1111);
      run_frame(5, 2, 4);
      en = 1'b0;
      step(0, 0, 0, 0);
      en = 1'b1;
      chk("en_clr_detected", detected, 0);
      chk("en_clr_best_valid", best_valid, 0);
      chk("en_clr_best_region", best_region, 0);
      chk("en_clr_rd_count", rd_count, 0);
      step(1, H - 1, V - 1, 1);
      idle(10);

      // Asynchronous reset in the middle of the scan.
      set_tgt(V * RW, V * RW, V * RW, V * RW);
      run_frame(5, 2, V);
      idle(2);
      chk("pre_rst_detected", detected, 4'b1111);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_detected", detected, 0);
      chk("arst_best_region", best_region, 0);
      chk("arst_best_valid", best_valid, 0);
      chk("arst_frame_done", frame_done, 0);
      chk("arst_rd_count", rd_count, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(12);

      // Recovery frame after reset.
      set_tgt($urandom_range(0, V * RW), $urandom_range(0, V * RW),
              $urandom_range(0, V * RW), $urandom_range(0, V * RW));
      run_frame(15, 8, V);
      wait_idle();
      idle(4);

      chk("abort_pulses", aborts_seen, m_aborts);
      chk("abort_pulses_nonzero", aborts_seen, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/region_color_tracker.md
Name: region_color_tracker

Overview:
Per-frame, per-region pixel-hit counter for the camera colour-detection path. It sits after the per-pixel colour classifier, which supplies the hit flag, and splits the active image into NUM_REGIONS vertical strips. At each frame end it snapshots the strip counts, applies hysteresis thresholds to produce per-strip detect flags, and scans the strips for the dominant one. Successor to the fixed 4-strip tracker: parametrised strip count and widths, runtime on/off thresholds, saturating counters, frame latching, argmax and count readback.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
NUM_REGIONS, 4, vertical strips (>=2); strip width RW = H_RES/NUM_REGIONS
CNT_W, 17, counter width; counters saturate at 2^CNT_W-1
X_W, 10, x coordinate width
Y_W, 10, y coordinate width
IDX_W, $clog2(NUM_REGIONS), region index width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  block enable; low = synchronous clear
pix_valid  in  1  x/y/hit valid this cycle
x  in  X_W  pixel column
y  in  Y_W  pixel row
hit  in  1  pixel matches target colour
thr_on  in  CNT_W  strip count strictly above this sets detect
thr_off  in  CNT_W  strip count strictly below this clears detect
detected  out  NUM_REGIONS  per-strip detect flags (hysteresis)
best_region  out  IDX_W  strip with highest latched count
best_valid  out  1  at least one detected bit set at last scan
frame_done  out  1  one-cycle pulse when results for a frame are complete
frame_abort  out  1  one-cycle pulse when a frame restarts before its end pixel
rd_sel  in  IDX_W  readback strip select
rd_count  out  CNT_W  latched count of strip rd_sel (combinational from shadow)

Behaviour:
- Reset (rst=1, async): all outputs 0, counters and shadows 0, in_frame=0, FSM=IDLE.
- en=0: on the clock edge, same clear as reset. Held until en=1.
- Start pixel: pix_valid && x==0 && y==0. Clears all counters, sets in_frame, counts the pixel itself. If in_frame was already 1, pulse frame_abort; results are not latched.
- End pixel: pix_valid && x==H_RES-1 && y==V_RES-1 while in_frame. The pixel is counted, in_frame is cleared, and LATCH is requested.
- Counting: only when in_frame && pix_valid && hit && x<NUM_REGIONS*RW && y<V_RES. Strip index is chosen by a comparator chain against k*RW; a division must not be used. Remainder columns are ignored. Increments saturate.
- The FSM (IDLE, LATCH, SCAN) is independent of counting, so a new frame may start during LATCH or SCAN.
- LATCH (1 cycle): shadow[i] <= count[i]. For each strip: if count>thr_on, detected[i]<=1; else if count<thr_off, detected[i]<=0; else hold. The set condition has priority if thr_off>thr_on.
- SCAN (NUM_REGIONS cycles): iterates i=0..N-1 over shadows and keeps the running max. A strict greater-than compare means ties go to the lowest index. On the final cycle: best_region<=argmax, best_valid<=|detected, frame_done pulses, FSM->IDLE.
- Latency (end pixel in cycle t): detected is updated at the end of cycle t+1; best_region, best_valid and frame_done are updated at the end of cycle t+1+N.
- An end pixel with in_frame=0 is ignored. Pixels with x>=H_RES or y>=V_RES are ignored.
- detected, best_region, best_valid and rd_count hold between frames until the next LATCH or SCAN completion.

Decomposition:
- Shared package color_track_pkg: default H_RES/V_RES constants; FSM state enum (IDLE, LATCH, SCAN).
- Sub-module region_index: combinational x -> {in_range, idx} comparator chain, parametrised by NUM_REGIONS and RW.
- Counters, shadows, hysteresis and argmax scan stay in the top module.

Test Plan:
- Full frame, hit only in x<160 (all 480 lines), thr_on=20000, thr_off=10000 -> count0=76800, others 0; detected=0001, best_region=0, best_valid=1; frame_done at end-pixel cycle +6 for N=4.
- Hysteresis: frame1 strip2 count 25000, frame2 15000, frame3 5000 (thr 20000/10000) -> detected[2] reads 1, 1, 0.
- Tie: strips 1 and 3 each with 30000 hits -> best_region=1.
- Frame restart: start pixel, 1000 hits, then a second start pixel before the end pixel -> frame_abort pulse, no frame_done; the following full frame counts only its own hits.
- Saturation with CNT_W=8: 300 hits in strip 0 -> rd_sel=0 gives rd_count=255.
- Async rst mid-SCAN -> all outputs 0 immediately, no frame_done; en=0 for one cycle mid-frame -> counters cleared, detected=0, FSM IDLE.
